// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Performs the request-to-send handshake (clock inhibit, then start bit),
// shifts out 8 data bits LSB first plus odd parity on the device's falling
// clock edges, releases data for the stop bit and samples the device
// acknowledge. A per-edge watchdog aborts a frame if the device stops clocking.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 13000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    ACK   = 3'd5
  } state_t;

  state_t           state;
  logic [7:0]       filter;
  logic [7:0]       filter_next;
  logic             f_ps2c;
  logic             f_ps2c_next;
  logic             fall_edge;
  logic             d_meta;
  logic             d_sync;
  logic [8:0]       shift;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // Odd parity bit: 1 when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Debounce the device clock: only 8 identical samples move the filtered level.
  always_comb begin
    filter_next = {ps2c_in, filter[7:1]};
    if (filter_next == 8'hFF) begin
      f_ps2c_next = 1'b1;
    end else if (filter_next == 8'h00) begin
      f_ps2c_next = 1'b0;
    end else begin
      f_ps2c_next = f_ps2c;
    end
    fall_edge = f_ps2c & ~f_ps2c_next;
  end

  // Clock filter registers and 2-FF synchronizer for the data line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter <= 8'h00;
      f_ps2c <= 1'b0;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      filter <= filter_next;
      f_ps2c <= f_ps2c_next;
      d_meta <= ps2d_in;
      d_sync <= d_meta;
    end
  end

  // Frame sequencer with registered line enables and status ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
      shift        <= 9'd0;
      inh_cnt      <= '0;
      bit_cnt      <= 4'd0;
      tmo_cnt      <= '0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
      case (state)
        IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          if (wr_ps2) begin
            shift   <= {odd_parity(din), din};
            inh_cnt <= INH_LOAD;
            ps2c_oe <= 1'b1;
            tx_idle <= 1'b0;
            state   <= RTS;
          end
        end
        RTS: begin
          if (inh_cnt == '0) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            tmo_cnt <= '0;
            state   <= START;
          end else begin
            inh_cnt <= inh_cnt - INH_W'(1);
          end
        end
        START, DATA, STOP: begin
          if (fall_edge) begin
            tmo_cnt <= '0;
            if (state == START) begin
              ps2d_oe <= ~shift[0];
              shift   <= {1'b0, shift[8:1]};
              bit_cnt <= 4'd8;
              state   <= DATA;
            end else if (state == DATA) begin
              if (bit_cnt != 4'd0) begin
                ps2d_oe <= ~shift[0];
                shift   <= {1'b0, shift[8:1]};
                bit_cnt <= bit_cnt - 4'd1;
              end else begin
                ps2d_oe <= 1'b0;
                state   <= STOP;
              end
            end else begin
              // 11th edge: the acknowledge decision is taken here directly.
              tx_done_tick <= ~d_sync;
              tx_err_tick  <= d_sync;
              tx_idle      <= 1'b1;
              state        <= IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tx_err_tick <= 1'b1;
            ps2c_oe     <= 1'b0;
            ps2d_oe     <= 1'b0;
            tx_idle     <= 1'b1;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ACK: begin
          // Never entered in normal flow; release the bus and recover.
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain bus model, PS/2 device model,
// frame scoreboard fed by the stimulus and drained by an output monitor.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;

  int checks = 0;
  int errors = 0;
  int rts_count = 0;
  int tick_total = 0;

  typedef struct {
    bit         expect_done;
    bit         has_bits;
    logic [9:0] bits;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];

  // Open-drain lines with pull-ups: anyone driving low wins.
  assign ps2c_in = ~(ps2c_oe | dev_clk_low);
  assign ps2d_in = ~(ps2d_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .tx_err_tick(tx_err_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame as seen by the device: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic pulse_wr(input logic [7:0] d);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din = d;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din = 8'($urandom);
  endtask

  // Device: waits for the start bit, then clocks nedges falling edges.
  // With nedges < 11 it stops holding the clock low mid-frame.
  task automatic device(input int nedges, input bit ack);
    logic [9:0] bits;
    int n;
    bits = 10'd0;
    n = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL dev_start_wait: no start bit within 300 cycles, required start");
      return;
    end
    repeat (30) @(negedge clk);
    for (int k = 1; k <= nedges; k++) begin
      dev_clk_low = 1'b1;
      if (k == nedges && nedges < 11) begin
        repeat (12) @(negedge clk);
        return;
      end
      repeat (20) @(negedge clk);
      if (k <= 10) bits[k-1] = ps2d_in;
      dev_clk_low = 1'b0;
      if (k == 10) begin
        cap_q.push_back(bits);
        if (ack) dev_data_low = 1'b1;
      end
      repeat (20) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_idle !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_idle, 1);
    check("frame_retired", exp_q.size(), 0);
  endtask

  task automatic send(input logic [7:0] d, input bit ack);
    exp_t e;
    int r0;
    e.expect_done = ack;
    e.has_bits = 1'b1;
    e.bits = frame_bits(d);
    r0 = rts_count;
    exp_q.push_back(e);
    pulse_wr(d);
    device(11, ack);
    wait_idle("idle_after_frame");
    check("one_rts_per_frame", rts_count - r0, 1);
  endtask

  // Monitor: measure each clock-inhibit window and the start bit that follows.
  initial begin
    int hi_cnt;
    hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi_cnt = 0;
      end else if (ps2c_oe) begin
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        check("rts_len", hi_cnt, INH);
        check("start_bit_driven", ps2d_oe, 1);
        rts_count++;
        hi_cnt = 0;
      end
    end
  end

  // Monitor: retire one scoreboard entry per completion/error tick.
  initial begin
    exp_t e;
    logic [9:0] c;
    bit prev_tick;
    prev_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_done_tick || tx_err_tick) begin
        tick_total++;
        check("tick_exclusive", tx_done_tick & tx_err_tick, 0);
        check("tick_not_back_to_back", prev_tick, 0);
        check("idle_at_tick", tx_idle, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: done=%0b err=%0b, required no tick", tx_done_tick, tx_err_tick);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", tx_done_tick, e.expect_done);
          check("outcome_err", tx_err_tick, !e.expect_done);
          if (e.has_bits) begin
            if (cap_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_capture: no bits captured, required %0h", e.bits);
            end else begin
              c = cap_q.pop_front();
              check("frame_bits", c, e.bits);
            end
          end
        end
      end
      prev_tick = tx_done_tick | tx_err_tick;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int n;
    int r0;
    int t0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ps2c_oe", ps2c_oe, 0);
    check("rst_ps2d_oe", ps2d_oe, 0);
    check("rst_tx_idle", tx_idle, 1);
    check("rst_ticks", {tx_done_tick, tx_err_tick}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Acked frame and nacked frame
    send(8'hED, 1'b1);
    send(8'h00, 1'b0);

    // Second request during DATA must be ignored
    e.expect_done = 1'b1;
    e.has_bits = 1'b1;
    e.bits = frame_bits(8'h3C);
    r0 = rts_count;
    exp_q.push_back(e);
    pulse_wr(8'h3C);
    fork
      device(11, 1'b1);
      begin
        repeat (150) @(negedge clk);
        check("busy_in_data", tx_idle, 0);
        pulse_wr(8'hFF);
      end
    join
    wait_idle("idle_after_ignored_wr");
    repeat (100) @(negedge clk);
    check("no_second_frame", rts_count - r0, 1);
    check("still_idle", tx_idle, 1);

    // Device never clocks: timeout
    e.expect_done = 1'b0;
    e.has_bits = 1'b0;
    e.bits = 10'd0;
    exp_q.push_back(e);
    pulse_wr(8'($urandom));
    n = 0;
    while (ps2d_oe !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_start_seen", ps2d_oe, 1);
    n = 0;
    while (tx_err_tick !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("tmo_ps2c_oe", ps2c_oe, 0);
    check("tmo_ps2d_oe", ps2d_oe, 0);
    check("tmo_tx_idle", tx_idle, 1);
    repeat (20) @(negedge clk);

    // Reset pulse at the 5th device edge
    t0 = tick_total;
    pulse_wr(8'h00);
    device(5, 1'b1);
    check("pre_reset_data_driven", ps2d_oe, 1);
    check("pre_reset_busy", tx_idle, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ps2c_oe", ps2c_oe, 0);
    check("midrst_ps2d_oe", ps2d_oe, 0);
    check("midrst_tx_idle", tx_idle, 1);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("no_tick_after_reset", tick_total - t0, 0);
    send(8'hA5, 1'b1);

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("capture_empty", cap_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 13000, number of clk cycles the host holds the PS/2 clock low for request-to-send (at least 100 us at the 100 MHz system clock).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, maximum number of clk cycles allowed between device clock falling edges before the frame is aborted.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_ps2  input  1  single-cycle request to send din.
REQ-006 din  input  8  command byte sent to the device (LED set, typematic, reset, ...).
REQ-007 ps2c_in  input  1  sampled PS/2 clock line.
REQ-008 ps2d_in  input  1  sampled PS/2 data line.
REQ-009 ps2c_oe  output  1  1 = drive the PS/2 clock low; 0 = release the line (open-drain, external pull-up).
REQ-010 ps2d_oe  output  1  1 = drive the PS/2 data low; 0 = release the line.
REQ-011 tx_idle  output  1  1 = no frame in progress; gates rx_en of the keyboard receiver.
REQ-012 tx_done_tick  output  1  one-cycle pulse when the device acknowledges the frame.
REQ-013 tx_err_tick  output  1  one-cycle pulse on a missing acknowledge or a timeout.

Function
REQ-014 ps2c_in SHALL pass through an 8-sample shift filter: the filtered clock becomes 1 on 8 consecutive ones, becomes 0 on 8 consecutive zeros, and otherwise holds; fall_edge = filtered 1 -> 0.
REQ-015 ps2d_in SHALL pass through a 2-FF synchronizer before use.
REQ-016 States: IDLE, RTS, START, DATA, STOP, ACK.
REQ-017 IDLE: tx_idle=1, both oe=0; when wr_ps2=1, latch {~^din, din} into a 9-bit shift register (odd parity in MSB), load the inhibit counter with INHIBIT_CYCLES-1, and go to RTS.
REQ-018 RTS: ps2c_oe=1, ps2d_oe=0; decrement the counter each cycle; at 0, go to START. ps2c_oe SHALL be high for exactly INHIBIT_CYCLES cycles.
REQ-019 START: ps2c_oe=0, ps2d_oe=1 (start bit 0); on the first fall_edge, drive shift-reg bit0 (ps2d_oe = ~bit), shift right, load bit counter 8, and go to DATA.
REQ-020 DATA: on each fall_edge, if the bit counter is not 0, output the next shift-reg bit (LSB first, parity last) and decrement; if the bit counter is 0, release data (ps2d_oe=0, stop bit) and go to STOP.
REQ-021 STOP: on fall_edge, sample synchronized data and go to ACK decision. Sampled 0 -> tx_done_tick=1; sampled 1 -> tx_err_tick=1. In both cases, go to IDLE the same cycle.
REQ-022 Device clock falling-edge sequence: 1-8 data bits, 9 parity, 10 stop/release, 11 ack sample.
REQ-023 Timeout counter: cleared on entering START and on every fall_edge, counts in START/DATA/STOP. Reaching TIMEOUT_CYCLES-1 -> tx_err_tick=1, both oe=0, go to IDLE.
REQ-024 wr_ps2 SHALL be ignored in every state except IDLE; din is sampled only on acceptance.
REQ-025 ps2c_oe and ps2d_oe SHALL be registered outputs (glitch-free); ps2c_oe=1 only in RTS.
REQ-026 tx_done_tick and tx_err_tick SHALL be mutually exclusive and never asserted in consecutive cycles for one frame.
REQ-027 Counter widths SHALL be sized by $clog2 of the parameters; no wrap occurs inside a frame.

Reset
REQ-028 Reset SHALL force IDLE immediately, with ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, tx_err_tick=0, filter=0x00, filtered clock=0, and all counters and the shift register at 0.
REQ-029 Reset mid-frame SHALL release both lines in the same cycle it asserts; no tick is generated.

Verification (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500; device model clocks at a 40-cycle period)
REQ-030 wr_ps2 with din=0xED, device acks low at edge 11 -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released; one tx_done_tick; tx_idle returns to 1.
REQ-031 din=0x00, device leaves data high at edge 11 -> parity bit 1; one tx_err_tick; no tx_done_tick.
REQ-032 wr_ps2 in IDLE -> ps2c_oe high for exactly 20 cycles, then ps2d_oe=1 with ps2c_oe=0.
REQ-033 Second wr_ps2 (din=0xFF) during DATA -> ignored; the frame in flight completes with the original byte; no second frame.
REQ-034 Device never clocks after START -> tx_err_tick 500 cycles after START entry; both oe=0; tx_idle=1.
REQ-035 Reset pulse at edge 5 of a frame -> both oe=0 the same cycle; no ticks; the next wr_ps2 is accepted normally.
